// File: rtl/mem_stage_lsu.sv
// Memory-access stage of the in-order RV64 pipeline.
// Non-memory ops pass through; loads/stores run a req/resp handshake.
`timescale 1ns/1ps
module mem_stage_lsu #(
    parameter int XLEN    = 64,
    parameter int INST_W  = 32,
    parameter int REGID_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_in,
    input  logic [REGID_W-1:0] rd_in,
    input  logic               wb_en_in,
    input  logic               ld_en,
    input  logic               st_en,
    input  logic [1:0]         size,
    input  logic               uns,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    st_data,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [INST_W-1:0]  inst_in,
    output logic               stall_mem,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [XLEN-1:0]    req_addr,
    output logic               req_wen,
    output logic [XLEN-1:0]    req_wdata,
    output logic [7:0]         req_wmask,
    input  logic               resp_valid,
    input  logic [XLEN-1:0]    resp_rdata,
    output logic               out_valid,
    output logic [REGID_W-1:0] out_rd,
    output logic               out_wb_en,
    output logic [XLEN-1:0]    out_data,
    output logic               misalign_err,
    output logic [XLEN-1:0]    pc_out,
    output logic [INST_W-1:0]  inst_out
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [REGID_W-1:0] rd_q;
    logic               wb_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               wen_q;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [7:0]         wmask_q;
    logic [XLEN-1:0]    pc_q;
    logic [INST_W-1:0]  inst_q;
    logic [XLEN-1:0]    rdata_q;

    logic               mem_op;
    logic               misaligned;
    logic               accept;
    logic [7:0]         mask_base;
    logic [7:0]         lane_mask;
    logic [XLEN-1:0]    lane_wdata;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    load_val;

    assign mem_op = ld_en | st_en;

    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = alu_result[0];
            2'd2: misaligned = |alu_result[1:0];
            2'd3: misaligned = |alu_result[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        mask_base = 8'h00;
        unique case (size)
            2'd0: mask_base = 8'h01;
            2'd1: mask_base = 8'h03;
            2'd2: mask_base = 8'h0F;
            2'd3: mask_base = 8'hFF;
            default: mask_base = 8'h00;
        endcase
    end

    assign lane_mask  = mask_base << alu_result[2:0];
    assign lane_wdata = st_data << {alu_result[2:0], 3'b000};

    assign accept = (state == IDLE) && !flush_in && mem_op && !misaligned;

    // Load path works from the latched doubleword, so DONE is glitch-free.
    assign shifted = rdata_q >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_val = shifted;
        unique case (size_q)
            2'd0: load_val = {{(XLEN-8){shifted[7] & ~uns_q}},
                              shifted[7:0]};
            2'd1: load_val = {{(XLEN-16){shifted[15] & ~uns_q}},
                              shifted[15:0]};
            2'd2: load_val = {{(XLEN-32){shifted[31] & ~uns_q}},
                              shifted[31:0]};
            2'd3: load_val = shifted;
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
            pc_q    <= '0;
            inst_q  <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rd_q    <= rd_in;
                wb_q    <= wb_en_in;
                size_q  <= size;
                uns_q   <= uns;
                wen_q   <= st_en;
                addr_q  <= alu_result;
                wdata_q <= lane_wdata;
                wmask_q <= lane_mask;
                pc_q    <= pc_in;
                inst_q  <= inst_in;
            end
            if (state == WAIT && resp_valid) begin
                rdata_q <= resp_rdata;
            end
        end
    end

    assign req_addr  = {addr_q[XLEN-1:3], 3'b000};
    assign req_wen   = wen_q;
    assign req_wdata = wdata_q;
    assign req_wmask = wmask_q;

    always_comb begin
        state_nxt    = state;
        stall_mem    = 1'b0;
        req_valid    = 1'b0;
        out_valid    = 1'b0;
        out_rd       = '0;
        out_wb_en    = 1'b0;
        out_data     = '0;
        misalign_err = 1'b0;
        pc_out       = pc_q;
        inst_out     = inst_q;
        unique case (state)
            IDLE: begin
                pc_out   = pc_in;
                inst_out = inst_in;
                if (!flush_in) begin
                    if (!mem_op) begin
                        out_valid = 1'b1;
                        out_rd    = rd_in;
                        out_wb_en = wb_en_in;
                        out_data  = alu_result;
                    end else if (misaligned) begin
                        out_valid    = 1'b1;
                        out_rd       = rd_in;
                        misalign_err = 1'b1;
                    end else begin
                        stall_mem = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                stall_mem = 1'b1;
                req_valid = 1'b1;
                if (req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall_mem = 1'b1;
                if (resp_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_rd    = rd_q;
                out_wb_en = wb_q & ~wen_q;
                out_data  = wen_q ? '0 : load_val;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs go quiet the moment reset is asserted, not at the next edge.
        if (!rst) begin
            stall_mem    = 1'b0;
            req_valid    = 1'b0;
            out_valid    = 1'b0;
            out_rd       = '0;
            out_wb_en    = 1'b0;
            out_data     = '0;
            misalign_err = 1'b0;
            pc_out       = '0;
            inst_out     = '0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a delay-configurable memory responder.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_in = 1'b1;
    logic [4:0]  rd_in = '0;
    logic        wb_en_in = 1'b0;
    logic        ld_en = 1'b0;
    logic        st_en = 1'b0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic [63:0] alu_result = '0;
    logic [63:0] st_data = '0;
    logic [63:0] pc_in = '0;
    logic [31:0] inst_in = '0;
    logic        stall_mem;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic [63:0] out_data;
    logic        misalign_err;
    logic [63:0] pc_out;
    logic [31:0] inst_out;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .flush_in(flush_in), .rd_in(rd_in),
        .wb_en_in(wb_en_in), .ld_en(ld_en), .st_en(st_en), .size(size),
        .uns(uns), .alu_result(alu_result), .st_data(st_data),
        .pc_in(pc_in), .inst_in(inst_in), .stall_mem(stall_mem),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata),
        .req_wmask(req_wmask), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .out_valid(out_valid), .out_rd(out_rd),
        .out_wb_en(out_wb_en), .out_data(out_data),
        .misalign_err(misalign_err), .pc_out(pc_out), .inst_out(inst_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        chk_data;
        logic        wb;
        logic        err;
        logic [4:0]  rd;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    logic        manual = 1'b0;
    logic        expect_req = 1'b0;
    logic        early_resp = 1'b0;
    int          ready_dly = 0;
    int          resp_dly = 1;
    logic [63:0] mem_rdata = '0;
    logic [63:0] exp_addr = '0;
    logic [63:0] exp_wdata = '0;
    logic [7:0]  exp_wmask = '0;
    logic        exp_wen = 1'b0;
    logic [63:0] pc_cnt = 64'h100;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ld_model(logic [63:0] raw,
                                             logic [2:0] off,
                                             logic [1:0] sz, logic u);
        int nb;
        logic [63:0] r;
        nb = 1 << sz;
        r = '0;
        for (int i = 0; i < nb; i++) r[8*i +: 8] = raw[8*(off+i) +: 8];
        if (!u && nb < 8 && r[8*nb-1])
            for (int i = 8*nb; i < 64; i++) r[i] = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_wb_en", out_wb_en, e.wb);
                chk("misalign_err", misalign_err, e.err);
                chk("out_rd", out_rd, e.rd);
                chk("pc_out", pc_out, e.pc);
                if (e.chk_data) chk("out_data", out_data, e.data);
            end
        end
    end

    initial begin
        req_ready = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (!manual && rst && req_valid) begin
                if (!expect_req) chk("unexpected_req", 1, 0);
                chk("req_addr", req_addr, exp_addr);
                chk("req_wen", req_wen, exp_wen);
                chk("req_wmask", req_wmask, exp_wmask);
                if (exp_wen) chk("req_wdata", req_wdata, exp_wdata);
                for (int i = 0; i < ready_dly; i++) begin
                    @(negedge clk);
                    chk("req_hold_valid", req_valid, 1);
                    chk("req_hold_addr", req_addr, exp_addr);
                end
                req_ready = 1'b1;
                if (early_resp) begin
                    resp_valid = 1'b1;
                    resp_rdata = ~mem_rdata;
                end
                @(negedge clk);
                req_ready = 1'b0;
                resp_valid = 1'b0;
                chk("req_drop", req_valid, 0);
                for (int i = 1; i < resp_dly; i++) @(negedge clk);
                resp_valid = 1'b1;
                resp_rdata = mem_rdata;
                @(negedge clk);
                resp_valid = 1'b0;
            end
        end
    end

    task automatic issue(logic ld, logic st, logic [1:0] sz, logic u,
                         logic [63:0] addr, logic [63:0] sd,
                         logic [63:0] raw, logic [4:0] rdi, logic wbi,
                         logic fl, int rdy, int rsp);
        int nb;
        int n;
        int exp_stall;
        logic [2:0] off;
        logic mem;
        logic mis;
        exp_t e;
        nb = 1 << sz;
        off = addr[2:0];
        mem = ld | st;
        mis = (int'(off) % nb) != 0;
        pc_cnt += 4;
        flush_in = fl; ld_en = ld; st_en = st; size = sz; uns = u;
        alu_result = addr; st_data = sd; rd_in = rdi; wb_en_in = wbi;
        pc_in = pc_cnt; inst_in = $urandom;
        ready_dly = rdy; resp_dly = rsp; mem_rdata = raw;
        exp_addr = {addr[63:3], 3'b000};
        exp_wen = st;
        exp_wmask = '0;
        for (int i = 0; i < nb; i++) exp_wmask[int'(off)+i] = 1'b1;
        exp_wdata = sd << (8*int'(off));
        expect_req = mem && !mis && !fl;
        exp_stall = expect_req ? 1 + (rdy + 1) + rsp : 0;
        if (!fl) begin
            e.wb = mem ? (ld && !st && !mis && wbi) : wbi;
            e.err = mem && mis;
            e.chk_data = !mem || (ld && !st && !mis);
            e.data = mem ? ld_model(raw, off, sz, u) : addr;
            e.rd = rdi;
            e.pc = pc_cnt;
            sb.push_back(e);
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall_mem) break;
            n++;
            if (n > 60) begin
                chk("stall_timeout", n, exp_stall);
                break;
            end
        end
        chk("stall_cycles", n, exp_stall);
        chk("final_req_valid", req_valid, 0);
        if (fl) chk("flush_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        flush_in = 1'b1; ld_en = 1'b0; st_en = 1'b0;
        expect_req = 1'b0;
    endtask

    initial begin
        logic [1:0] sz;
        logic [2:0] off;
        // reset with live pass-through inputs: outputs must stay zero
        flush_in = 1'b0; alu_result = 64'h55; wb_en_in = 1'b1;
        pc_in = 64'hABC;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall", stall_mem, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_pc_out", pc_out, 0);
        flush_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        issue(0, 0, 2'd3, 0, 64'h1234, 0, 0, 5'd3, 1, 0, 0, 1);
        issue(1, 0, 2'd0, 0, 64'h1003, 0, 64'h0000_0000_8000_0000,
              5'd4, 1, 0, 0, 1);
        issue(1, 0, 2'd0, 1, 64'h1003, 0, 64'h0000_0000_8000_0000,
              5'd5, 1, 0, 0, 1);
        issue(0, 1, 2'd1, 0, 64'h1006, 64'hBEEF, 0, 5'd6, 1, 0, 0, 1);
        chk("sh_wmask_const", exp_wmask, 8'hC0);
        issue(1, 0, 2'd3, 0, 64'h2008, 0, 64'hDEAD_BEEF_0123_4567,
              5'd7, 1, 0, 3, 2);
        issue(1, 0, 2'd2, 0, 64'h1002, 0, 0, 5'd8, 1, 0, 0, 1);
        issue(1, 0, 2'd2, 0, 64'h1000, 0, 0, 5'd9, 1, 1, 0, 1);
        early_resp = 1'b1;
        issue(1, 0, 2'd2, 0, 64'h3004, 0, 64'h8765_4321_0000_0000,
              5'd10, 1, 0, 0, 1);
        early_resp = 1'b0;
        issue(0, 0, 2'd0, 0, 64'hFFFF_0000_0000_0001, 0, 0,
              5'd11, 0, 0, 0, 1);

        for (int k = 0; k < 10; k++) begin
            sz = 2'($urandom_range(0, 3));
            off = 3'($urandom_range(0, 7));
            off = off & ~3'((1 << sz) - 1);
            issue($urandom_range(0, 1) == 1, 0, sz, $urandom_range(0, 1) == 1,
                  64'h8000_0000 + 64'(k*64) + 64'(off), 0,
                  {$urandom, $urandom}, 5'(k + 12), 1, 0,
                  $urandom_range(0, 2), $urandom_range(1, 3));
            sz = 2'($urandom_range(0, 3));
            off = 3'($urandom_range(0, 7)) & ~3'((1 << sz) - 1);
            issue(0, 1, sz, 0, 64'h9000_0000 + 64'(off),
                  {$urandom, $urandom}, 0, 5'(k), 1, 0,
                  $urandom_range(0, 2), $urandom_range(1, 3));
        end

        // reset while the access sits in WAIT
        manual = 1'b1;
        flush_in = 1'b0; ld_en = 1'b1; size = 2'd3; uns = 1'b0;
        alu_result = 64'h2000; rd_in = 5'd1; wb_en_in = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        chk("wait_stall", stall_mem, 1);
        chk("wait_req_valid", req_valid, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_stall", stall_mem, 0);
        chk("arst_req_valid", req_valid, 0);
        chk("arst_out_valid", out_valid, 0);
        flush_in = 1'b1; ld_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        resp_valid = 1'b1;
        resp_rdata = 64'h1111;
        @(negedge clk);
        chk("post_rst_stall", stall_mem, 0);
        @(posedge clk); #1;
        resp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        manual = 1'b0;
        issue(0, 0, 2'd3, 0, 64'h77, 0, 0, 5'd2, 1, 0, 0, 1);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
